// File: rtl/msg_fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// msg_fifo_rr_scheduler
//
// Round-robin scheduler that shares one downstream message path between
// CHANNEL first-word-fall-through receive FIFOs. A grant drains exactly one
// complete message: one header beat plus ceil(data_field_len/16) payload
// beats. Messages are never interleaved. The next grant is decided in a single
// IDLE cycle, so there is one bubble cycle between consecutive messages.
//
// Header beat layout (128 bits):
//   [127:120] src_id  [119:112] des_id  [111:104] data_type
//   [103:96]  data_channel              [95:80]   data_field_len (bytes)
//
// Optional feature (compile-time macro MSG_SCHED_TIMEOUT_EN):
//   When defined, a stall counter aborts a message whose FIFO stays empty for
//   TIMEOUT_CYC cycles in the payload phase. The abort pulses timeout_o, skips
//   the eof beat and moves on to the next channel. When undefined, the
//   scheduler waits indefinitely and timeout_o is constant 0.
//
// Ports:
//   sys_clk_i   - single clock
//   rst_i       - synchronous reset, active-high
//   rd_en_o     - per-FIFO pop (only the granted bit can be 1)
//   rd_din_i    - FWFT data, channel i at rd_din_i[i*128 +: 128]
//   rd_empty_i  - per-FIFO empty flag
//   m_valid_o   - output beat valid
//   m_ready_i   - downstream ready
//   m_data_o    - output beat
//   m_sof_o     - header beat marker
//   m_eof_o     - last beat of the message
//   m_chan_o    - source FIFO index, constant for a whole message
//   busy_o      - high whenever the FSM is not in IDLE
//   err_len_o   - 1-cycle pulse when an over-length header is accepted
//   timeout_o   - 1-cycle abort pulse (optional feature only)
// -----------------------------------------------------------------------------
module msg_fifo_rr_scheduler #(
    parameter int CHANNEL       = 6,
    parameter int DATA_W        = 128,
    parameter int MAX_PAY_BEATS = 256,
    parameter int CH_W          = 4,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    output logic [CHANNEL-1:0]        rd_en_o,
    input  logic [CHANNEL*DATA_W-1:0] rd_din_i,
    input  logic [CHANNEL-1:0]        rd_empty_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [DATA_W-1:0]         m_data_o,
    output logic                      m_sof_o,
    output logic                      m_eof_o,
    output logic [CH_W-1:0]           m_chan_o,
    output logic                      busy_o,
    output logic                      err_len_o,
    output logic                      timeout_o
);

    localparam int CNT_W = $clog2(MAX_PAY_BEATS + 1);

    // An illegal parameter set never pops, so it cannot corrupt any FIFO.
    localparam bit CFG_OK = (CHANNEL >= 2) && (CHANNEL <= 16) &&
                            ((1 << CH_W) >= CHANNEL) && (DATA_W == 128) &&
                            (MAX_PAY_BEATS >= 1) && (TIMEOUT_CYC >= 1);

    localparam logic [16:0]      MAX_PAY_17  = 17'(MAX_PAY_BEATS);
    localparam logic [CNT_W-1:0] MAX_PAY_CNT = CNT_W'(MAX_PAY_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_e;

    // Payload beat count from the byte length; 17 bits so 0xFFFF gives 4096.
    function automatic logic [16:0] calc_pay(input logic [15:0] len);
        logic [16:0] sum;
        sum      = {1'b0, len} + 17'd15;
        calc_pay = sum >> 4;
    endfunction

    // Registers
    state_e           state_q;
    logic [CH_W-1:0]  grant_q;
    logic [CH_W-1:0]  last_grant_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic             m_sof_q;
    logic             m_eof_q;
    logic [CH_W-1:0]  m_chan_q;
    logic             err_len_q;

    // Combinational values
    logic [DATA_W-1:0] cur_din_s;
    logic              cur_empty_s;
    logic              pop_s;
    logic [CHANNEL-1:0] rd_en_s;
    logic              arb_found_s;
    logic [CH_W-1:0]   arb_idx_s;
    logic [16:0]       pay_raw_s;
    logic              pay_over_s;
    logic [CNT_W-1:0]  pay_d;
    logic              eof_d;

`ifdef MSG_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_q;
    logic               timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Granted-channel data/empty mux and the pop decision for that channel.
    always_comb begin
        cur_din_s   = '0;
        cur_empty_s = 1'b1;
        for (int i = 0; i < CHANNEL; i++) begin
            if (grant_q == CH_W'(i)) begin
                cur_din_s   = rd_din_i[i*DATA_W +: DATA_W];
                cur_empty_s = rd_empty_i[i];
            end else begin
                cur_din_s   = cur_din_s;
                cur_empty_s = cur_empty_s;
            end
        end
        // Pops are suppressed during reset so no FIFO word is lost to it.
        pop_s = CFG_OK && !rst_i &&
                ((state_q == ST_HDR) || (state_q == ST_PAY)) &&
                !cur_empty_s && (!m_valid_q || m_ready_i);
        rd_en_s = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            rd_en_s[i] = pop_s && (grant_q == CH_W'(i));
        end
    end

    // Round-robin search: first non-empty channel above last_grant, then wrap.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        for (int i = 0; i < CHANNEL; i++) begin
            if (!arb_found_s && !rd_empty_i[i] && (CH_W'(i) > last_grant_q)) begin
                arb_found_s = 1'b1;
                arb_idx_s   = CH_W'(i);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
        for (int i = 0; i < CHANNEL; i++) begin
            if (!arb_found_s && !rd_empty_i[i] && (CH_W'(i) <= last_grant_q)) begin
                arb_found_s = 1'b1;
                arb_idx_s   = CH_W'(i);
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Header length decode with clamp, and eof detection for the current pop.
    always_comb begin
        pay_raw_s  = calc_pay(cur_din_s[95:80]);
        pay_over_s = (pay_raw_s > MAX_PAY_17);
        if (pay_over_s) begin
            pay_d = MAX_PAY_CNT;
        end else begin
            pay_d = pay_raw_s[CNT_W-1:0];
        end
        case (state_q)
            ST_HDR:  eof_d = (pay_d == '0);
            ST_PAY:  eof_d = (beat_cnt_q == CNT_W'(1));
            default: eof_d = 1'b0;
        endcase
    end

    // Scheduler FSM together with the registered output beat stage.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(CHANNEL - 1);
            beat_cnt_q   <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            m_chan_q     <= '0;
            err_len_q    <= 1'b0;
`ifdef MSG_SCHED_TIMEOUT_EN
            stall_q      <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            err_len_q <= 1'b0;
`ifdef MSG_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
            if (pop_s || (state_q != ST_PAY)) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q;
            end
`endif
            // Output register: load on pop, otherwise drain when accepted.
            if (pop_s) begin
                m_data_q  <= cur_din_s;
                m_valid_q <= 1'b1;
                m_sof_q   <= (state_q == ST_HDR);
                m_eof_q   <= eof_d;
                m_chan_q  <= grant_q;
            end else if (m_ready_i) begin
                m_valid_q <= 1'b0;
            end else begin
                m_valid_q <= m_valid_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (arb_found_s) begin
                        grant_q <= arb_idx_s;
                        state_q <= ST_HDR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    if (pop_s) begin
                        beat_cnt_q <= pay_d;
                        err_len_q  <= pay_over_s;
                        if (eof_d) begin
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                        end else begin
                            state_q <= ST_PAY;
                        end
                    end else begin
                        state_q <= ST_HDR;
                    end
                end
                ST_PAY: begin
                    if (pop_s) begin
                        beat_cnt_q <= beat_cnt_q - CNT_W'(1);
                        if (eof_d) begin
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                        end else begin
                            state_q <= ST_PAY;
                        end
                    end
`ifdef MSG_SCHED_TIMEOUT_EN
                    // Abort: no eof beat; a beat already in m_data_q still drains.
                    else if (cur_empty_s) begin
                        if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
                            timeout_q    <= 1'b1;
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                            beat_cnt_q   <= '0;
                            stall_q      <= '0;
                        end else begin
                            stall_q <= stall_q + STALL_W'(1);
                        end
                    end
`endif
                    else begin
                        state_q <= ST_PAY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en_o   = rd_en_s;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_sof_o   = m_sof_q;
    assign m_eof_o   = m_eof_q;
    assign m_chan_o  = m_chan_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign err_len_o = err_len_q;

endmodule

// File: tb/tb_msg_fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for msg_fifo_rr_scheduler. Per-channel FIFOs are modelled
// with queues; every loaded message pushes its expected beats to a scoreboard
// queue in the order the round-robin should deliver them, and a monitor pops
// and compares each beat accepted downstream.
// -----------------------------------------------------------------------------
module tb_msg_fifo_rr_scheduler;

    localparam int CH   = 6;
    localparam int DW   = 128;
    localparam int MAXP = 256;
    localparam int CHW  = 4;
    localparam int TO   = 16;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic [CH-1:0]      rd_en_o;
    logic [CH*DW-1:0]   rd_din_i = '0;
    logic [CH-1:0]      rd_empty_i = '1;
    logic               m_valid_o;
    logic               m_ready_i = 1'b1;
    logic [DW-1:0]      m_data_o;
    logic               m_sof_o;
    logic               m_eof_o;
    logic [CHW-1:0]     m_chan_o;
    logic               busy_o;
    logic               err_len_o;
    logic               timeout_o;

    always #5 clk = ~clk;

    msg_fifo_rr_scheduler #(
        .CHANNEL(CH), .DATA_W(DW), .MAX_PAY_BEATS(MAXP), .CH_W(CHW), .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk_i (clk),
        .rst_i     (rst_i),
        .rd_en_o   (rd_en_o),
        .rd_din_i  (rd_din_i),
        .rd_empty_i(rd_empty_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_sof_o   (m_sof_o),
        .m_eof_o   (m_eof_o),
        .m_chan_o  (m_chan_o),
        .busy_o    (busy_o),
        .err_len_o (err_len_o),
        .timeout_o (timeout_o)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         sof;
        logic         eof;
        logic [3:0]   chan;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] fifo_q[CH][$];
    int n_chk = 0, n_err = 0, cyc = 0;
    int pops[CH];
    int last_pop_cyc[CH];
    int err_cnt = 0, to_cnt = 0, to_cyc = 0, last_eof_cyc = 0;
    bit ready_pat = 1'b0, gap_en = 1'b0, prev_eof = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input int ch, input int len, input int tag);
        logic [127:0] h;
        h = '0;
        h[127:120] = 8'(ch);
        h[119:112] = 8'h5A;
        h[111:104] = 8'h01;
        h[103:96]  = 8'(ch);
        h[95:80]   = 16'(len);
        h[31:0]    = 32'(tag);
        return h;
    endfunction

    function automatic logic [127:0] mk_pay(input int ch, input int tag, input int k);
        return {32'hDA7A0000 | 32'(ch), 32'(tag), 32'(k), 32'h600DF00D};
    endfunction

    task automatic exp_beat(input logic [127:0] d, input bit sof, input bit eof, input int ch);
        beat_t b;
        b.data = d; b.sof = sof; b.eof = eof; b.chan = 4'(ch);
        exp_q.push_back(b);
    endtask

    task automatic push_pay(input int ch, input int tag, input int k0, input int k1,
                            input int pay, input bit exp_en);
        for (int k = k0; k <= k1; k++) begin
            fifo_q[ch].push_back(mk_pay(ch, tag, k));
            if (exp_en) exp_beat(mk_pay(ch, tag, k), 1'b0, (k == pay), ch);
        end
    endtask

    task automatic load_msg(input int ch, input int len, input int npay,
                            input int tag, input bit exp_en);
        int pay;
        pay = (len + 15) >> 4;
        if (pay > MAXP) pay = MAXP;
        fifo_q[ch].push_back(mk_hdr(ch, len, tag));
        if (exp_en) exp_beat(mk_hdr(ch, len, tag), 1'b1, (pay == 0), ch);
        push_pay(ch, tag, 1, npay, pay, exp_en);
    endtask

    // FIFO model: pop on rd_en at the edge, present new head 1 ns later.
    task automatic fifo_loop();
        forever begin
            @(posedge clk);
            cyc++;
            chk("rd_en_onehot", 128'($onehot0(rd_en_o)), 128'd1);
            for (int i = 0; i < CH; i++) begin
                if (rd_en_o[i]) begin
                    chk("pop_when_empty", rd_empty_i[i], 1'b0);
                    if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
                    pops[i]++;
                    last_pop_cyc[i] = cyc;
                end
            end
            #1;
            for (int i = 0; i < CH; i++) begin
                rd_empty_i[i] = (fifo_q[i].size() == 0);
                rd_din_i[i*DW +: DW] = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
            end
            if (ready_pat) m_ready_i = ((cyc % 3) == 0);
        end
    endtask

    // Monitor: compare each accepted beat against the scoreboard head.
    task automatic mon_loop();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (err_len_o) err_cnt++;
                if (timeout_o) begin to_cnt++; to_cyc = cyc; end
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", m_valid_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", m_data_o, e.data);
                        chk("sof_eof_chan", {m_sof_o, m_eof_o, m_chan_o}, {e.sof, e.eof, e.chan});
                        if (gap_en && m_sof_o && prev_eof) chk("bubble_gap", cyc - last_eof_cyc, 2);
                        prev_eof = m_eof_o;
                        if (m_eof_o) last_eof_cyc = cyc;
                    end
                end
            end
        end
    endtask

    task automatic reset_on();
        @(posedge clk); #2;
        rst_i = 1'b1;
        for (int i = 0; i < CH; i++) begin fifo_q[i].delete(); pops[i] = 0; end
        exp_q.delete();
        prev_eof = 1'b0; err_cnt = 0; to_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {m_valid_o, m_sof_o, m_eof_o, m_chan_o, busy_o, err_len_o, timeout_o, rd_en_o}, '0);
        chk("rst_data", m_data_o, '0);
    endtask

    task automatic reset_off();
        @(posedge clk); #2;
        rst_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_o && !m_valid_o) break;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_idle", busy_o, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin pops[i] = 0; last_pop_cyc[i] = 0; end
        fork
            fifo_loop();
            mon_loop();
        join_none

        // 1: ch0 then ch3, len=32, one bubble between messages.
        reset_on();
        load_msg(0, 32, 2, 10, 1'b1);
        load_msg(3, 32, 2, 13, 1'b1);
        gap_en = 1'b1;
        reset_off();
        wait_drain(100);
        chk("t1_pops_ch0", pops[0], 3);
        chk("t1_pops_ch3", pops[3], 3);

        // 2: every FIFO holds back-to-back len=0 messages; order 0..5,0..5.
        reset_on();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < CH; c++) load_msg(c, 0, 0, 20 + r * 8 + c, 1'b1);
        reset_off();
        wait_drain(200);
        gap_en = 1'b0;

        // 3: ch2 len=40 with a 1,0,0 ready pattern; 4 pops, eof on last only.
        reset_on();
        load_msg(2, 40, 3, 30, 1'b1);
        ready_pat = 1'b1;
        reset_off();
        wait_drain(200);
        ready_pat = 1'b0;
        m_ready_i = 1'b1;
        chk("t3_pops_ch2", pops[2], 4);

        // 4: over-length header clamps to 256 payload beats; next word is a header.
        reset_on();
        load_msg(1, 16'hFFFF, MAXP, 40, 1'b1);
        load_msg(1, 0, 0, 41, 1'b1);
        reset_off();
        wait_drain(1000);
        chk("t4_err_len_pulses", err_cnt, 1);
        chk("t4_pops_ch1", pops[1], MAXP + 2);

        // 5: ch4 runs dry after 2 of 4 payload beats, ch5 waiting.
        reset_on();
        load_msg(4, 64, 2, 50, 1'b1);
`ifdef MSG_SCHED_TIMEOUT_EN
        load_msg(5, 0, 0, 51, 1'b1);
        reset_off();
        wait_drain(200);
        chk("t5_timeout_pulses", to_cnt, 1);
        chk("t5_timeout_delay", to_cyc - last_pop_cyc[4], TO);
        chk("t5_pops_ch5", pops[5], 1);
`else
        load_msg(5, 0, 0, 51, 1'b0);
        reset_off();
        repeat (40) @(negedge clk);
        chk("t5_stall_busy", busy_o, 1'b1);
        chk("t5_stall_beats_seen", exp_q.size(), 0);
        chk("t5_ch5_not_served", pops[5], 0);
        push_pay(4, 50, 3, 4, 4, 1'b1);
        exp_beat(mk_hdr(5, 0, 51), 1'b1, 1'b1, 5);
        wait_drain(100);
        chk("t5_pops_ch4", pops[4], 5);
        chk("t5_no_timeout", to_cnt, 0);
`endif

        // 6: reset in the middle of a ch2 payload; ch0 wins afterwards.
        reset_on();
        load_msg(2, 64, 4, 60, 1'b1);
        reset_off();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_q.size() <= 3) break;
        end
        chk("t6_in_payload", busy_o, 1'b1);
        reset_on();
        load_msg(0, 0, 0, 61, 1'b1);
        load_msg(2, 0, 0, 62, 1'b1);
        reset_off();
        wait_drain(50);
        chk("t6_pops_ch0", pops[0], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
